// File: rtl/sha256_digest_receiver_if.sv
// rtl/sha256_digest_receiver_if.sv - digest stream and status bundle between host and receiver
//
// Purpose: groups the word stream, control strobes and status outputs of
// sha256_digest_receiver so the host side and the receiver share one port.
// Ports (signals):
//   start, in_valid, in_word, expected, digest_ack   host -> receiver
//   digest, digest_valid, match, busy, word_count,
//   overrun, timeout                                 receiver -> host
// Modports: master = host side, slave = receiver side.
interface sha256_digest_receiver_if #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 16
);
  localparam int DIG_W = WORD_W * NUM_WORDS;
  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  logic             start;
  logic             in_valid;
  logic [WORD_W-1:0] in_word;
  logic [DIG_W-1:0] expected;
  logic             digest_ack;

  logic [DIG_W-1:0] digest;
  logic             digest_valid;
  logic             match;
  logic             busy;
  logic [CNT_W-1:0] word_count;
  logic             overrun;
  logic             timeout;

  modport master (
    output start, in_valid, in_word, expected, digest_ack,
    input  digest, digest_valid, match, busy, word_count, overrun, timeout
  );

  modport slave (
    input  start, in_valid, in_word, expected, digest_ack,
    output digest, digest_valid, match, busy, word_count, overrun, timeout
  );
endinterface

// File: rtl/sha256_digest_receiver.sv
// rtl/sha256_digest_receiver.sv - reassembles the 256-bit SHA256 digest from a 16-bit word stream
//
// Purpose: collects NUM_WORDS words MSB-first into a digest, compares it with
// the expected value and reports match / overrun / timeout status.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    sha256_digest_receiver_if.slave (stream in, status out)
module sha256_digest_receiver #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  sha256_digest_receiver_if.slave  bus
);
  localparam int DIG_W  = WORD_W * NUM_WORDS;
  localparam int CNT_W  = $clog2(NUM_WORDS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t            state;
  logic [DIG_W-1:0]  digest_r;
  logic              match_r;
  logic              overrun_r;
  logic              timeout_r;
  logic [CNT_W-1:0]  count_r;
  logic [IDLE_W-1:0] idle_r;

  logic              last_word;
  logic [DIG_W-1:0]  shifted;

  assign last_word = (count_r == CNT_W'(NUM_WORDS - 1));
  // Digest as it will look once the current word is shifted in; also used
  // for the match compare so match lands on the same edge as DONE.
  assign shifted   = {digest_r[DIG_W-WORD_W-1:0], bus.in_word};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      digest_r  <= '0;
      match_r   <= 1'b0;
      overrun_r <= 1'b0;
      timeout_r <= 1'b0;
      count_r   <= '0;
      idle_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= COLLECT;
            digest_r  <= '0;
            count_r   <= '0;
            idle_r    <= '0;
            overrun_r <= 1'b0;
            timeout_r <= 1'b0;
          end
        end

        COLLECT: begin
          if (bus.start) begin
            // Restart: any word presented on this cycle is dropped.
            digest_r  <= '0;
            count_r   <= '0;
            idle_r    <= '0;
            overrun_r <= 1'b0;
            timeout_r <= 1'b0;
          end else if (bus.in_valid) begin
            digest_r <= shifted;
            count_r  <= count_r + 1'b1;
            idle_r   <= '0;
            if (last_word) begin
              state   <= DONE;
              match_r <= (shifted == bus.expected);
            end
          end else begin
            idle_r <= idle_r + 1'b1;
            // Partial digest and word count are left in place for debug.
            if (idle_r == IDLE_W'(TIMEOUT - 1)) begin
              timeout_r <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        DONE: begin
          if (bus.start) begin
            state     <= COLLECT;
            digest_r  <= '0;
            count_r   <= '0;
            idle_r    <= '0;
            overrun_r <= 1'b0;
            timeout_r <= 1'b0;
          end else begin
            if (bus.in_valid) overrun_r <= 1'b1;
            if (bus.digest_ack) state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.digest       = digest_r;
  assign bus.digest_valid = (state == DONE);
  assign bus.match        = match_r;
  assign bus.busy         = (state == COLLECT);
  assign bus.word_count   = count_r;
  assign bus.overrun      = overrun_r;
  assign bus.timeout      = timeout_r;
endmodule

// File: tb/tb_sha256_digest_receiver.sv
// tb/tb_sha256_digest_receiver.sv - scoreboard bench for sha256_digest_receiver
module tb_sha256_digest_receiver;
  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  sha256_digest_receiver_if bus ();

  sha256_digest_receiver #(.WORD_W(16), .NUM_WORDS(16), .TIMEOUT(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [255:0] digest;
    logic         match;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] abc_v = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  logic [15:0]  abc_w [16];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs settle #1 after the active edge and are checked there.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_exp(input logic [255:0] d, input logic m);
    exp_t e;
    e.digest = d;
    e.match  = m;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_digest"}, bus.digest, 256'(0));
    check_eq({tag, "_dvalid"}, 256'(bus.digest_valid), 256'(0));
    check_eq({tag, "_match"}, 256'(bus.match), 256'(0));
    check_eq({tag, "_busy"}, 256'(bus.busy), 256'(0));
    check_eq({tag, "_count"}, 256'(bus.word_count), 256'(0));
    check_eq({tag, "_overrun"}, 256'(bus.overrun), 256'(0));
    check_eq({tag, "_timeout"}, 256'(bus.timeout), 256'(0));
  endtask

  // Scoreboard monitor: every rising digest_valid consumes one expectation.
  logic dv_q = 1'b0;
  always @(negedge clock) begin
    if (bus.digest_valid && !dv_q) begin
      check_eq("sb_pending", 256'(sb.size() > 0), 256'(1));
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_digest", bus.digest, e.digest);
        check_eq("sb_match", 256'(bus.match), 256'(e.match));
        check_eq("sb_count", 256'(bus.word_count), 256'(16));
      end
    end
    dv_q = bus.digest_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] partial;

    for (int i = 0; i < 16; i++) abc_w[i] = abc_v[255-16*i -: 16];

    bus.start      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_word    = '0;
    bus.expected   = abc_v;
    bus.digest_ack = 1'b0;

    // Reset state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rst");

    // Digest "abc", back-to-back words
    pulse_start();
    check_eq("abc_busy", 256'(bus.busy), 256'(1));
    push_exp(abc_v, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check_eq("abc_not_done", 256'(bus.digest_valid), 256'(0));
      send_word(abc_w[i]);
    end
    check_eq("abc_dvalid", 256'(bus.digest_valid), 256'(1));
    check_eq("abc_busy_lo", 256'(bus.busy), 256'(0));

    // start and digest_ack in the same DONE cycle: start wins
    bus.start      = 1'b1;
    bus.digest_ack = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.digest_ack = 1'b0;
    check_eq("sa_busy", 256'(bus.busy), 256'(1));
    check_eq("sa_count", 256'(bus.word_count), 256'(0));
    check_eq("sa_dvalid", 256'(bus.digest_valid), 256'(0));
    check_eq("sa_digest", bus.digest, 256'(0));

    // Mismatch with 3-cycle gaps
    bus.expected = {abc_v[255:16], 16'h15ac};
    push_exp(abc_v, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send_word(abc_w[i]);
      if (i < 15) idle(3);
    end
    check_eq("mm_dvalid", 256'(bus.digest_valid), 256'(1));
    check_eq("mm_match", 256'(bus.match), 256'(0));
    check_eq("mm_timeout", 256'(bus.timeout), 256'(0));

    // Overrun in DONE, then ack
    send_word(16'h1234);
    check_eq("ov_flag", 256'(bus.overrun), 256'(1));
    check_eq("ov_digest", bus.digest, abc_v);
    check_eq("ov_dvalid", 256'(bus.digest_valid), 256'(1));
    bus.digest_ack = 1'b1;
    tick();
    bus.digest_ack = 1'b0;
    check_eq("ack_dvalid", 256'(bus.digest_valid), 256'(0));
    check_eq("ack_digest", bus.digest, abc_v);
    check_eq("ack_count", 256'(bus.word_count), 256'(16));
    check_eq("ack_overrun", 256'(bus.overrun), 256'(1));

    // Timeout after 5 words
    pulse_start();
    check_eq("to_ov_clr", 256'(bus.overrun), 256'(0));
    for (int i = 0; i < 5; i++) send_word(abc_w[i]);
    idle(63);
    check_eq("to_early_flag", 256'(bus.timeout), 256'(0));
    check_eq("to_early_busy", 256'(bus.busy), 256'(1));
    idle(1);
    check_eq("to_flag", 256'(bus.timeout), 256'(1));
    check_eq("to_busy", 256'(bus.busy), 256'(0));
    check_eq("to_dvalid", 256'(bus.digest_valid), 256'(0));
    check_eq("to_count", 256'(bus.word_count), 256'(5));
    partial = {176'b0, abc_v[255:176]};
    check_eq("to_digest", bus.digest, partial);
    send_word(16'hbeef);
    check_eq("idle_ignore", 256'(bus.word_count), 256'(5));
    pulse_start();
    check_eq("to_clr", 256'(bus.timeout), 256'(0));
    check_eq("to_rearm", 256'(bus.busy), 256'(1));

    // Restart mid-collect, restart word discarded
    for (int i = 0; i < 7; i++) send_word(16'h1111 * 16'(i + 1));
    check_eq("rs_count7", 256'(bus.word_count), 256'(7));
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_word  = 16'hdead;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("rs_count0", 256'(bus.word_count), 256'(0));
    check_eq("rs_digest0", bus.digest, 256'(0));
    bus.expected = abc_v;
    push_exp(abc_v, 1'b1);
    for (int i = 0; i < 16; i++) send_word(abc_w[i]);
    check_eq("rs_dvalid", 256'(bus.digest_valid), 256'(1));

    // Reset mid-collect
    pulse_start();
    for (int i = 0; i < 10; i++) send_word(abc_w[i]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("mrst");
    for (int i = 0; i < 16; i++) send_word(abc_w[i]);
    check_eq("nostart_count", 256'(bus.word_count), 256'(0));
    check_eq("nostart_digest", bus.digest, 256'(0));
    check_eq("nostart_dvalid", 256'(bus.digest_valid), 256'(0));

    idle(2);
    check_eq("sb_drained", 256'(sb.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
